pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_ret_stack.sv | 45 ++++
 rtl/pc_stack_unit.sv | 128 ++++++++++++
 tb/tb_pc_stack_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC select encoding for the PC/stack unit
package pc_pkg;

    localparam int PC_W_DEF        = 10;
    localparam int OFF_W_DEF       = 7;
    localparam int HALT_ADDR_DEF   = 63;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        NPC_HOLD   = 3'd0,
        NPC_RET    = 3'd1,
        NPC_CALL   = 3'd2,
        NPC_JUMP   = 3'd3,
        NPC_BRANCH = 3'd4,
        NPC_INC    = 3'd5
    } npc_sel_e;

    // Depth counter width: enough to hold the value STACK_DEPTH itself.
    function automatic int depth_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - return-address LIFO: one register array plus an entry count
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int W     = PC_W_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic                          CLK,
    input  logic                          init,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  push_data,
    output logic [W-1:0]                  top,
    output logic [$clog2(DEPTH):0]        depth,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_m1;

    assign count_m1 = count - 1'b1;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign depth    = count;
    // Contents under an empty stack are stale but never selected by the caller.
    assign top      = mem[count_m1[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (init) begin
            count <= '0;
        end else if (push && !full) begin
            mem[count[AW-1:0]] <= push_data;
            count              <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count_m1;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with relative branch, call/return stack and halt detection
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int OFF_W       = OFF_W_DEF,
    parameter int HALT_ADDR   = HALT_ADDR_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                            CLK,
    input  logic                            init,
    input  logic                            stall,
    input  logic                            jump_en,
    input  logic                            branch_en,
    input  logic                            call_en,
    input  logic                            ret_en,
    input  logic [OFF_W-1:0]                offset,
    input  logic [PC_W-1:0]                 destination,
    output logic [PC_W-1:0]                 PC,
    output logic                            halt,
    output logic                            stack_err,
    output logic [$clog2(STACK_DEPTH):0]    stack_depth
);

    localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_push;
    logic            stk_pop;
    logic            set_halt;
    logic            set_err;
    logic            halt_q;
    logic            err_q;
    npc_sel_e        sel;

    assign pc_inc  = pc_q + 1'b1;
    assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

    pc_ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .init      (init),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .depth     (stack_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Only the highest-priority request is acted on; lower ones have no side effects.
    always_comb begin
        sel      = NPC_INC;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        set_halt = 1'b0;
        set_err  = 1'b0;
        if (init) begin
            sel = NPC_HOLD;
        end else if (halt_q || (pc_q > HALT_PC)) begin
            sel      = NPC_HOLD;
            set_halt = 1'b1;
        end else if (stall) begin
            sel = NPC_HOLD;
        end else if (ret_en) begin
            if (stk_empty) begin
                sel      = NPC_HOLD;
                set_halt = 1'b1;
                set_err  = 1'b1;
            end else begin
                sel     = NPC_RET;
                stk_pop = 1'b1;
            end
        end else if (call_en) begin
            if (stk_full) begin
                sel      = NPC_HOLD;
                set_halt = 1'b1;
                set_err  = 1'b1;
            end else begin
                sel      = NPC_CALL;
                stk_push = 1'b1;
            end
        end else if (jump_en) begin
            sel = NPC_JUMP;
        end else if (branch_en) begin
            sel = NPC_BRANCH;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            NPC_HOLD:   pc_d = pc_q;
            NPC_RET:    pc_d = stk_top;
            NPC_CALL:   pc_d = destination;
            NPC_JUMP:   pc_d = destination;
            NPC_BRANCH: pc_d = pc_q + off_ext;
            NPC_INC:    pc_d = pc_inc;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (set_halt) halt_q <= 1'b1;
            if (set_err)  err_q  <= 1'b1;
        end
    end

    assign PC        = pc_q;
    assign halt      = halt_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed and randomized checks of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;

    logic       CLK;
    logic       init;
    logic       stall;
    logic       jump_en;
    logic       branch_en;
    logic       call_en;
    logic       ret_en;
    logic [6:0] offset;
    logic [9:0] destination;
    logic [9:0] PC;
    logic       halt;
    logic       stack_err;
    logic [2:0] stack_depth;

    int n_checks;
    int n_fails;

    int m_pc;
    bit m_halt;
    bit m_err;
    int m_stk[$];

    pc_stack_unit #(
        .PC_W        (10),
        .OFF_W       (7),
        .HALT_ADDR   (63),
        .STACK_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .init        (init),
        .stall       (stall),
        .jump_en     (jump_en),
        .branch_en   (branch_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .offset      (offset),
        .destination (destination),
        .PC          (PC),
        .halt        (halt),
        .stack_err   (stack_err),
        .stack_depth (stack_depth)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: one architectural step from the rules, using a queue as the stack.
    task automatic model_step();
        int off;
        if (init) begin
            m_pc = 0; m_halt = 0; m_err = 0;
            m_stk.delete();
        end else if (m_halt || m_pc > 63) begin
            m_halt = 1;
        end else if (stall) begin
        end else if (ret_en) begin
            if (m_stk.size() == 0) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (call_en) begin
            if (m_stk.size() == 4) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_stk.push_back((m_pc + 1) % 1024);
                m_pc = int'(destination);
            end
        end else if (jump_en) begin
            m_pc = int'(destination);
        end else if (branch_en) begin
            off  = int'($signed(offset));
            m_pc = (m_pc + off) & 1023;
        end else begin
            m_pc = (m_pc + 1) % 1024;
        end
    endtask

    task automatic set_in(input bit i, input bit s, input bit r, input bit c,
                          input bit j, input bit b, input logic [6:0] o, input logic [9:0] d);
        init = i; stall = s; ret_en = r; call_en = c;
        jump_en = j; branch_en = b; offset = o; destination = d;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_val({tag, "_pc"},    int'(PC),          m_pc);
        check_val({tag, "_halt"},  int'(halt),        int'(m_halt));
        check_val({tag, "_err"},   int'(stack_err),   int'(m_err));
        check_val({tag, "_depth"}, int'(stack_depth), m_stk.size());
    endtask

    task automatic idle(); set_in(0,0,0,0,0,0,7'd0,10'd0); endtask

    initial begin
        n_checks = 0; n_fails = 0;
        m_pc = 0; m_halt = 0; m_err = 0;
        idle();
        @(negedge CLK);

        set_in(1,0,0,0,0,0,7'd0,10'd0); tick("reset");
        check_val("reset_pc0", int'(PC), 0);
        check_val("reset_halt0", int'(halt), 0);
        for (int k = 1; k <= 5; k++) begin
            idle(); tick("idle");
            check_val("idle_count", int'(PC), k);
        end

        set_in(0,0,0,0,1,0,7'd0,10'd10); tick("j10");
        set_in(0,0,0,0,0,1,7'h7D,10'd0); tick("br_m3");
        check_val("br_m3_exp", int'(PC), 7);
        set_in(1,0,0,0,0,0,7'd0,10'd0); tick("init2");
        set_in(0,0,0,0,0,1,7'h7F,10'd0); tick("br_wrap");
        check_val("br_wrap_exp", int'(PC), 1023);
        idle(); tick("wrap_halt");
        check_val("wrap_halt_flag", int'(halt), 1);
        check_val("wrap_halt_pc", int'(PC), 1023);
        idle(); tick("halt_hold");

        set_in(1,0,0,0,0,0,7'd0,10'd0); tick("init3");
        set_in(0,0,0,0,1,0,7'd0,10'd5); tick("j5");
        set_in(0,0,0,1,0,0,7'd0,10'd20); tick("call20");
        check_val("call20_pc", int'(PC), 20);
        idle(); tick("c_inc");
        set_in(0,0,0,1,0,0,7'd0,10'd40); tick("call40");
        check_val("call40_depth", int'(stack_depth), 2);
        set_in(0,0,1,0,0,0,7'd0,10'd0); tick("ret1");
        check_val("ret1_pc", int'(PC), 22);
        set_in(0,0,1,0,0,0,7'd0,10'd0); tick("ret2");
        check_val("ret2_pc", int'(PC), 6);
        check_val("ret2_depth", int'(stack_depth), 0);

        set_in(1,0,0,0,0,0,7'd0,10'd0); tick("init4");
        for (int k = 0; k < 5; k++) begin
            set_in(0,0,0,1,0,0,7'd0,10'd8); tick("call8");
        end
        check_val("ovf_pc", int'(PC), 8);
        check_val("ovf_err", int'(stack_err), 1);
        check_val("ovf_halt", int'(halt), 1);
        check_val("ovf_depth", int'(stack_depth), 4);

        set_in(1,0,0,1,0,0,7'd0,10'd33); tick("init_call");
        check_val("init_call_pc", int'(PC), 0);
        check_val("init_call_err", int'(stack_err), 0);
        check_val("init_call_depth", int'(stack_depth), 0);

        set_in(0,0,1,0,0,0,7'd0,10'd0); tick("unf");
        check_val("unf_pc", int'(PC), 0);
        check_val("unf_err", int'(stack_err), 1);
        check_val("unf_halt", int'(halt), 1);

        set_in(1,0,0,0,0,0,7'd0,10'd0); tick("init5");
        set_in(0,0,0,0,1,0,7'd0,10'd12); tick("j12");
        set_in(0,1,0,0,1,0,7'd0,10'd30); tick("stall_j");
        check_val("stall_pc", int'(PC), 12);
        set_in(0,0,0,1,1,1,7'h05,10'd30); tick("multi");
        check_val("multi_pc", int'(PC), 30);
        check_val("multi_depth", int'(stack_depth), 1);

        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 3) == 0),
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0,
                   7'($urandom_range(0, 127)),
                   10'($urandom_range(0, 70)));
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
